// File: rtl/priority_scheduler_if.sv
// priority_scheduler_if
// Output handshake between the priority scheduler (master) and its single
// consumer (slave).
//   out_valid_o : master -> slave, out_index_o holds a granted channel
//   out_index_o : master -> slave, granted channel index (plain binary)
//   out_ready_i : slave -> master, consumer takes out_index_o this cycle
// Handshake: a transfer happens on every rising clk edge where out_valid_o
// and out_ready_i are both high. While out_valid_o=1 and out_ready_i=0 the
// master holds out_valid_o and out_index_o stable. out_valid_o never waits
// on out_ready_i, and out_ready_i may be high while out_valid_o is low.
interface priority_scheduler_if #(
  parameter int OUT_WIDTH = 3
);
  logic                 out_valid_o;
  logic [OUT_WIDTH-1:0] out_index_o;
  logic                 out_ready_i;

  modport master (
    output out_valid_o,
    output out_index_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o,
    input  out_index_o,
    output out_ready_i
  );
endinterface

// File: rtl/priority_scheduler.sv
// priority_scheduler
// Captures per-channel request events into a pending vector and hands one
// pending channel at a time to a shared consumer through a registered
// valid/ready output. Selection is either fixed (highest index wins) or
// round-robin (search downward from a pointer that follows the last grant),
// chosen at runtime by mode_i.
// Ports:
//   clk         : system clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   req_i       : per-channel request, each high cycle is one event
//   mode_i      : 0 = fixed priority, 1 = round-robin
//   out_if      : output handshake (out_valid_o, out_index_o, out_ready_i)
//   pending_o   : pending vector, excludes the channel held in the output
//   overflow_o  : sticky, a request hit a channel that was already pending
// Handshake on out_if: a grant is consumed on each edge with out_valid_o and
// out_ready_i both high; the output register reloads whenever it is empty
// or being consumed, and is held stable under backpressure.
module priority_scheduler #(
  parameter int INPUTS    = 8,
  parameter int OUT_WIDTH = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUTS-1:0]       req_i,
  input  logic                    mode_i,
  priority_scheduler_if.master    out_if,
  output logic [INPUTS-1:0]       pending_o,
  output logic                    overflow_o
);

  localparam logic [OUT_WIDTH-1:0] LAST_IDX = OUT_WIDTH'(INPUTS - 1);

  logic [INPUTS-1:0]    pending_q, pending_d;
  logic                 valid_q, valid_d;
  logic [OUT_WIDTH-1:0] index_q, index_d;
  logic [OUT_WIDTH-1:0] ptr_q, ptr_d;
  logic                 overflow_q, overflow_d;

  logic [OUT_WIDTH-1:0] sel_fix;
  logic [OUT_WIDTH-1:0] sel_rr;
  logic [OUT_WIDTH-1:0] sel;
  logic                 load;
  logic                 grant;
  logic [INPUTS-1:0]    clear_mask;

  // Fixed priority: ascending scan, so the last hit is the highest index.
  always_comb begin
    sel_fix = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (pending_q[i]) sel_fix = OUT_WIDTH'(i);
    end
  end

  // Round-robin: candidate k steps below ptr (wrapping). Scanning k from the
  // far end back toward ptr leaves the nearest pending channel in sel_rr.
  always_comb begin
    int                   idx;
    logic [OUT_WIDTH-1:0] idx_w;
    sel_rr = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      idx = int'(ptr_q) - k;
      if (idx < 0) idx = idx + INPUTS;
      idx_w = OUT_WIDTH'(idx);
      if (pending_q[idx_w]) sel_rr = idx_w;
    end
  end

  always_comb begin
    sel        = mode_i ? sel_rr : sel_fix;
    load       = !valid_q || out_if.out_ready_i;
    grant      = load && (pending_q != '0);
    clear_mask = grant ? (INPUTS'(1) << sel) : '0;

    // A request on the channel being cleared re-arms it and is not counted
    // as an overflow.
    pending_d  = (pending_q & ~clear_mask) | req_i;
    overflow_d = overflow_q | (|(req_i & pending_q & ~clear_mask));

    valid_d = valid_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = grant;
      if (grant) begin
        index_d = sel;
        if (mode_i) ptr_d = (sel == '0) ? LAST_IDX : sel - OUT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      ptr_q      <= LAST_IDX;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_if.out_valid_o = valid_q;
  assign out_if.out_index_o = index_q;
  assign pending_o          = pending_q;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_priority_scheduler.sv
// tb_priority_scheduler
// Self-checking bench for priority_scheduler (INPUTS=8): a hand-derived
// vector table, directed multi-cycle sequences and random stimulus, all
// compared every cycle against a behavioural model of the scheduling rules.
module tb_priority_scheduler;
  localparam int N = 8;
  localparam int W = 3;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic         mode_i;
  logic [N-1:0] pending_o;
  logic         overflow_o;

  priority_scheduler_if #(.OUT_WIDTH(W)) sif ();

  priority_scheduler #(.INPUTS(N), .OUT_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .mode_i     (mode_i),
    .out_if     (sif.master),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_pend[N];
  bit m_valid;
  int m_index;
  int m_ptr;
  bit m_ovf;

  // Candidate channels in priority order; first pending one wins.
  function automatic int pick(input bit rr);
    int order[$];
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) order.push_back(i);
    end else begin
      for (int k = 0; k < N; k++) order.push_back((m_ptr - k + N) % N);
    end
    foreach (order[j]) if (m_pend[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_edge(input logic [N-1:0] req, input bit mode, input bit ready, input bit rstn);
    int  g;
    bit  load;
    if (!rstn) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_index = 0;
      m_ptr   = N - 1;
      m_ovf   = 1'b0;
      return;
    end
    load = !m_valid || ready;
    g    = load ? pick(mode) : -1;
    for (int i = 0; i < N; i++) begin
      if (req[i] && m_pend[i] && i != g) m_ovf = 1'b1;
      m_pend[i] = (m_pend[i] && i != g) || req[i];
    end
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_index = g;
        if (mode) m_ptr = (g == 0) ? N - 1 : g - 1;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model at the edge and compares
  // all outputs 1 time unit after the edge.
  task automatic step(input logic [N-1:0] req, input bit mode, input bit ready, input bit rstn);
    req_i           = req;
    mode_i          = mode;
    sif.out_ready_i = ready;
    rst_n           = rstn;
    @(posedge clk);
    model_edge(req, mode, ready, rstn);
    #1;
    check("valid",    32'(sif.out_valid_o), 32'(m_valid));
    check("index",    32'(sif.out_index_o), 32'(m_index));
    check("pending",  32'(pending_o),       32'(pend_vec()));
    check("overflow", 32'(overflow_o),      32'(m_ovf));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         mode;
    logic         ready;
    logic         rstn;
    logic         e_valid;
    logic [W-1:0] e_index;
    logic [N-1:0] e_pend;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [N-1:0] req, input logic mode, input logic ready, input logic rstn,
                     input logic e_valid, input logic [W-1:0] e_index, input logic [N-1:0] e_pend,
                     input logic e_ovf);
    vec_t v;
    v.req = req; v.mode = mode; v.ready = ready; v.rstn = rstn;
    v.e_valid = e_valid; v.e_index = e_index; v.e_pend = e_pend; v.e_ovf = e_ovf;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N-1:0] r;
    bit           md, rd, rs;

    rst_n = 1'b0; req_i = '0; mode_i = 1'b0; sif.out_ready_i = 1'b1;

    // Reset with all requests high, release, then full fixed-priority drain.
    add(8'hFF, 0, 1, 0,  0, 0, 8'h00, 0);
    add(8'hFF, 0, 1, 0,  0, 0, 8'h00, 0);
    add(8'hFF, 0, 1, 1,  0, 0, 8'hFF, 0);
    add(8'h00, 0, 1, 1,  1, 7, 8'h7F, 0);
    add(8'h00, 0, 1, 1,  1, 6, 8'h3F, 0);
    add(8'h00, 0, 1, 1,  1, 5, 8'h1F, 0);
    add(8'h00, 0, 1, 1,  1, 4, 8'h0F, 0);
    add(8'h00, 0, 1, 1,  1, 3, 8'h07, 0);
    add(8'h00, 0, 1, 1,  1, 2, 8'h03, 0);
    add(8'h00, 0, 1, 1,  1, 1, 8'h01, 0);
    add(8'h00, 0, 1, 1,  1, 0, 8'h00, 0);
    add(8'h00, 0, 1, 1,  0, 0, 8'h00, 0);
    // Fixed drain of a single pulse.
    add(8'h25, 0, 1, 1,  0, 0, 8'h25, 0);
    add(8'h00, 0, 1, 1,  1, 5, 8'h05, 0);
    add(8'h00, 0, 1, 1,  1, 2, 8'h01, 0);
    add(8'h00, 0, 1, 1,  1, 0, 8'h00, 0);
    add(8'h00, 0, 1, 1,  0, 0, 8'h00, 0);
    // Backpressure: grant 5 held for 10 cycles, then drain.
    add(8'h25, 0, 0, 1,  0, 0, 8'h25, 0);
    add(8'h00, 0, 0, 1,  1, 5, 8'h05, 0);
    for (int i = 0; i < 10; i++) add(8'h00, 0, 0, 1,  1, 5, 8'h05, 0);
    add(8'h00, 0, 1, 1,  1, 2, 8'h01, 0);
    add(8'h00, 0, 1, 1,  1, 0, 8'h00, 0);
    add(8'h00, 0, 1, 1,  0, 0, 8'h00, 0);

    foreach (tbl[t]) begin
      step(tbl[t].req, tbl[t].mode, tbl[t].ready, tbl[t].rstn);
      check("tbl_valid",    32'(sif.out_valid_o), 32'(tbl[t].e_valid));
      check("tbl_index",    32'(sif.out_index_o), 32'(tbl[t].e_index));
      check("tbl_pending",  32'(pending_o),       32'(tbl[t].e_pend));
      check("tbl_overflow", 32'(overflow_o),      32'(tbl[t].e_ovf));
    end

    // Round-robin with req held at 8'h81: grants alternate 7, 0, 7, 0.
    step(8'h00, 1, 1, 0);
    step(8'h81, 1, 1, 1);
    step(8'h81, 1, 1, 1); check("rr_g0", 32'(sif.out_index_o), 32'd7);
    step(8'h81, 1, 1, 1); check("rr_g1", 32'(sif.out_index_o), 32'd0);
    step(8'h81, 1, 1, 1); check("rr_g2", 32'(sif.out_index_o), 32'd7);
    step(8'h81, 1, 1, 1); check("rr_g3", 32'(sif.out_index_o), 32'd0);

    // Fixed priority with the same held request: 7 every cycle.
    step(8'h00, 0, 1, 0);
    step(8'h81, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(8'h81, 0, 1, 1);
      check("fix_g", 32'(sif.out_index_o), 32'd7);
    end

    // Overflow: request on the held channel is not an overflow, a request
    // on an already pending channel is, and it sticks until reset.
    step(8'h00, 0, 0, 0);
    step(8'h08, 0, 0, 1);                                         // cycle 0
    step(8'h00, 0, 0, 1);
    check("ovf_held_idx", 32'(sif.out_index_o), 32'd3);
    step(8'h00, 0, 0, 1);
    step(8'h08, 0, 0, 1);                                         // cycle 3
    check("ovf_c3_pend", 32'(pending_o), 32'h08);
    check("ovf_c3_flag", 32'(overflow_o), 32'd0);
    step(8'h00, 0, 0, 1);
    step(8'h08, 0, 0, 1);                                         // cycle 5
    check("ovf_c5_flag", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 4; i++) step(8'h00, 0, 1, 1);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    step(8'h00, 0, 1, 0);
    check("ovf_reset", 32'(overflow_o), 32'd0);

    // Reset mid-operation with pending 8'h3C and a held grant; the pointer
    // was moved by a round-robin grant and must return to 7.
    step(8'h80, 1, 0, 1);
    step(8'h3C, 1, 0, 1);
    step(8'h00, 1, 0, 1);
    check("mid_pend", 32'(pending_o), 32'h3C);
    check("mid_held", 32'(sif.out_index_o), 32'd7);
    step(8'h00, 1, 0, 0);
    check("mid_rst_valid", 32'(sif.out_valid_o), 32'd0);
    check("mid_rst_index", 32'(sif.out_index_o), 32'd0);
    check("mid_rst_pend",  32'(pending_o), 32'h00);
    step(8'h81, 1, 1, 1);
    step(8'h00, 1, 1, 1);
    check("mid_rr_start", 32'(sif.out_index_o), 32'd7);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      md = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 50) != 0);
      step(r, md, rd, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
